// File: rtl/uart_frame_parser_pkg.sv
// Shared encodings for the UART frame parser: FSM states, error codes and the frame delimiter.
package uart_frame_parser_pkg;

    typedef enum logic [3:0] {
        S0_HUNT    = 4'd0,
        S1_SOF2    = 4'd1,
        S2_PAYLOAD = 4'd2,
        S3_EOF2    = 4'd3,
        S4_DONE    = 4'd4,
        S5_DRAIN   = 4'd5
    } state_t;

    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_BAD_SOF  = 2'd3;

    localparam logic [7:0] DELIM = 8'h26;

endpackage

// File: rtl/uart_frame_parser.sv
// Locates &&payload&& frames in the uart_rx byte stream and presents the stripped payload.
// state      | meaning
// S0_HUNT    | waiting for first '&'
// S1_SOF2    | expecting second '&'
// S2_PAYLOAD | collecting payload bytes
// S3_EOF2    | saw '&', deciding between end of frame and literal '&'
// S4_DONE    | publish shadow buffer, pulse frame_done
// S5_DRAIN   | after overflow, discard until '&&'
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int MAX_LEN    = 64,
    parameter int TIMEOUT_US = 1000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_vld,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic [7:0]           frame_len,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [1:0]           err_code
);

    localparam int          BUF_W       = 8 * MAX_LEN;
    localparam logic [31:0] TIMEOUT_CLK = 32'(CLK_FREQ / 1_000_000 * TIMEOUT_US - 1);

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [BUF_W-1:0]   shadow_q, shadow_d;
    logic               prev_amp_q, prev_amp_d;
    logic [31:0]        cnt_q, cnt_eff;
    logic               done_d, err_d;
    logic [1:0]         code_d;
    logic               is_amp, running, tmo_hit;

    function automatic logic [BUF_W-1:0] put_byte(input logic [BUF_W-1:0] buf_in,
                                                  input logic [7:0]       idx,
                                                  input logic [7:0]       val);
        logic [BUF_W-1:0] r;
        r = buf_in;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == 8'(i)) r[8*i +: 8] = val;
        end
        return r;
    endfunction

    assign is_amp  = (rx_data == DELIM);
    assign running = (state_q inside {S1_SOF2, S2_PAYLOAD, S3_EOF2, S5_DRAIN});
    // A byte arriving in the terminal cycle clears the count before it is compared.
    assign cnt_eff = rx_vld ? 32'd0 : cnt_q;
    assign tmo_hit = running && (cnt_eff == TIMEOUT_CLK);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        shadow_d   = shadow_q;
        prev_amp_d = prev_amp_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = err_code;
        unique case (state_q)
            S0_HUNT: begin
                if (rx_vld && is_amp) state_d = S1_SOF2;
            end
            S1_SOF2: begin
                if (rx_vld) begin
                    if (is_amp) begin
                        state_d  = S2_PAYLOAD;
                        len_d    = 8'd0;
                        shadow_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_SOF;
                        state_d = S0_HUNT;
                    end
                end
            end
            S2_PAYLOAD: begin
                if (rx_vld) begin
                    if (is_amp) begin
                        state_d = S3_EOF2;
                    end else if (len_q == 8'(MAX_LEN)) begin
                        err_d      = 1'b1;
                        code_d     = ERR_OVERFLOW;
                        prev_amp_d = 1'b0;
                        state_d    = S5_DRAIN;
                    end else begin
                        shadow_d = put_byte(shadow_q, len_q, rx_data);
                        len_d    = len_q + 8'd1;
                    end
                end
            end
            S3_EOF2: begin
                if (rx_vld) begin
                    if (is_amp) begin
                        state_d = S4_DONE;
                    end else if (len_q > 8'(MAX_LEN - 2)) begin
                        err_d      = 1'b1;
                        code_d     = ERR_OVERFLOW;
                        prev_amp_d = 1'b0;
                        state_d    = S5_DRAIN;
                    end else begin
                        // The held '&' was a literal payload byte, not a closing delimiter.
                        shadow_d = put_byte(put_byte(shadow_q, len_q, DELIM), len_q + 8'd1, rx_data);
                        len_d    = len_q + 8'd2;
                        state_d  = S2_PAYLOAD;
                    end
                end
            end
            S4_DONE: begin
                done_d  = 1'b1;
                state_d = S0_HUNT;
            end
            S5_DRAIN: begin
                if (rx_vld) begin
                    if (is_amp && prev_amp_q) begin
                        prev_amp_d = 1'b0;
                        state_d    = S0_HUNT;
                    end else begin
                        prev_amp_d = is_amp;
                    end
                end
            end
            default: state_d = S0_HUNT;
        endcase
        if (tmo_hit) begin
            state_d = S0_HUNT;
            if (state_q != S5_DRAIN) begin
                err_d  = 1'b1;
                code_d = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S0_HUNT;
            len_q      <= 8'd0;
            shadow_q   <= '0;
            prev_amp_q <= 1'b0;
            cnt_q      <= 32'd0;
            frame_data <= '0;
            frame_len  <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shadow_q   <= shadow_d;
            prev_amp_q <= prev_amp_d;
            cnt_q      <= (running && !tmo_hit) ? cnt_eff + 32'd1 : 32'd0;
            frame_done <= done_d;
            frame_err  <= err_d;
            err_code   <= code_d;
            if (done_d) begin
                frame_data <= shadow_q;
                frame_len  <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: scoreboard of expected done/err strobes checked by a monitor.
module tb_uart_frame_parser;

    localparam int MAX_LEN    = 64;
    localparam int CLK_FREQ   = 50_000_000;
    localparam int TIMEOUT_US = 20;
    localparam int TMO_CYC    = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int GAP        = 50;
    localparam logic [7:0] AMP = 8'h26;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [7:0]           rx_data;
    logic                 rx_vld;
    logic [8*MAX_LEN-1:0] frame_data;
    logic [7:0]           frame_len;
    logic                 frame_done;
    logic                 frame_err;
    logic [1:0]           err_code;

    typedef struct {
        logic                 is_err;
        logic [1:0]           code;
        logic [7:0]           len;
        logic [8*MAX_LEN-1:0] data;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [7:0]           pl[$];
    logic [8*MAX_LEN-1:0] model_data;
    logic [7:0]           model_len;
    logic [1:0]           model_code;
    int                   n_tests = 0;
    int                   n_fail  = 0;
    int                   hit;

    uart_frame_parser #(
        .CLK_FREQ  (CLK_FREQ),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .frame_data(frame_data),
        .frame_len (frame_len),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #10 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [8*MAX_LEN-1:0] obs, input logic [8*MAX_LEN-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic sendg(input logic [7:0] b);
        send(b);
        idle(GAP - 1);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.len    = 8'(pl.size());
        e.data   = '0;
        foreach (pl[i]) e.data[8*i +: 8] = pl[i];
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.len    = 8'd0;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic send_frame();
        push_done();
        sendg(AMP);
        sendg(AMP);
        foreach (pl[i]) sendg(pl[i]);
        sendg(AMP);
        send(AMP);
        @(negedge sys_clk);
        chk("done_not_early", frame_done, 1'b0);
        @(negedge sys_clk);
        chk("done_latency", frame_done, 1'b1);
        idle(GAP);
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        rx_vld     = 1'b0;
        rx_data    = 8'h00;
        model_data = '0;
        model_len  = 8'd0;
        model_code = 2'd0;
        idle(3);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_frame_data", frame_data, '0);
        chk("rst_frame_len", frame_len, 8'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        idle(2);

        fork
            forever begin
                @(negedge sys_clk);
                if (frame_done || frame_err) begin
                    chk("no_dual_strobe", frame_done & frame_err, 1'b0);
                    chk("strobe_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.is_err) begin
                            chk("err_strobe", frame_err, 1'b1);
                            chk("err_code", err_code, mon_e.code);
                            chk("err_data_kept", frame_data, model_data);
                            chk("err_len_kept", frame_len, model_len);
                            model_code = mon_e.code;
                        end else begin
                            chk("done_strobe", frame_done, 1'b1);
                            chk("frame_len", frame_len, mon_e.len);
                            chk("frame_data", frame_data, mon_e.data);
                            chk("err_code_held", err_code, model_code);
                            model_data = mon_e.data;
                            model_len  = mon_e.len;
                        end
                    end
                end
            end
        join_none

        // lone '&' inside payload, then empty frame
        pl = '{8'h61, AMP, 8'h62};
        send_frame();
        pl.delete();
        send_frame();

        // stray byte between start characters
        push_err(2'd3);
        sendg(AMP);
        send(8'h58);
        @(negedge sys_clk);
        chk("bad_sof_latency", frame_err, 1'b1);
        idle(GAP);

        pl = '{8'h41, 8'h42, 8'h43};
        send_frame();

        // 65 bytes: overflow on the last one, then drain until '&&'
        push_err(2'd1);
        sendg(AMP);
        sendg(AMP);
        for (int i = 0; i < 64; i++) sendg(8'(64 + i % 26));
        send(8'h5A);
        @(negedge sys_clk);
        chk("overflow_latency", frame_err, 1'b1);
        idle(GAP);
        sendg(8'h61);
        sendg(AMP);
        sendg(8'h62);
        sendg(AMP);
        sendg(AMP);
        chk("overflow_code_held", err_code, 2'd1);
        chk("overflow_data_kept", frame_data, model_data);
        pl = '{8'h78, 8'h79};
        send_frame();

        // exactly MAX_LEN bytes is accepted
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(64 + (i * 7) % 26));
        send_frame();

        // literal '&' pair that would exceed MAX_LEN
        push_err(2'd1);
        sendg(AMP);
        sendg(AMP);
        for (int i = 0; i < MAX_LEN - 1; i++) sendg(8'(65 + i % 20));
        sendg(AMP);
        sendg(8'h72);
        sendg(AMP);
        sendg(AMP);

        // literal '&' pair landing exactly on MAX_LEN
        pl.delete();
        for (int i = 0; i < MAX_LEN - 2; i++) pl.push_back(8'(66 + i % 20));
        pl.push_back(AMP);
        pl.push_back(8'h72);
        send_frame();

        // timeout after B: error visible TMO_CYC cycles later
        push_err(2'd2);
        sendg(AMP);
        sendg(AMP);
        sendg(8'h41);
        send(8'h42);
        hit = 0;
        for (int k = 1; k <= TMO_CYC + 50; k++) begin
            @(negedge sys_clk);
            if (frame_err && hit == 0) hit = k;
        end
        chk("timeout_cycle", hit, TMO_CYC);
        idle(GAP);

        // byte in the terminal-count cycle keeps the frame alive
        pl = '{8'h41, 8'h42, 8'h43};
        push_done();
        sendg(AMP);
        sendg(AMP);
        sendg(8'h41);
        send(8'h42);
        idle(TMO_CYC - 2);
        send(8'h43);
        idle(GAP - 1);
        sendg(AMP);
        send(AMP);
        idle(GAP);
        chk("late_byte_len", frame_len, 8'd3);

        // reset mid-frame
        sendg(AMP);
        sendg(AMP);
        sendg(8'h41);
        sendg(8'h42);
        #3;
        sys_rst_n = 1'b0;
        #2;
        model_data = '0;
        model_len  = 8'd0;
        model_code = 2'd0;
        chk("midrst_frame_data", frame_data, '0);
        chk("midrst_frame_len", frame_len, 8'd0);
        chk("midrst_strobes", {frame_done, frame_err}, 2'b00);
        chk("midrst_err_code", err_code, 2'd0);
        idle(3);
        sys_rst_n = 1'b1;
        idle(GAP);
        pl = '{8'h5A};
        send_frame();

        idle(2 * GAP);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
